// File: rtl/wb_write_queue_pkg.sv
// wb_pkg: shared widths, queue entry type and pointer wrap helper for wb_write_queue
package wb_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
    return (32'(ptr) == depth - 1) ? '0 : ptr + PTR_W'(1);
  endfunction
endpackage

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: EX handshake, register-file write port and forwarding lookup bundle
interface wb_write_queue_if import wb_pkg::*; #(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);
  logic              ex_valid;
  logic              ex_regwrite;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_data;
  logic              ex_ready;
  logic              drain_en;
  logic [ADDR_W-1:0] Rd_EXWB;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd_IFID;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              full;
  modport slave (
    input  ex_valid, ex_regwrite, ex_rd, ex_data, drain_en, Rd_IFID,
    output ex_ready, Rd_EXWB, Write_Data, RegWrite, fwd_hit, fwd_data, full
  );
  modport master (
    output ex_valid, ex_regwrite, ex_rd, ex_data, drain_en, Rd_IFID,
    input  ex_ready, Rd_EXWB, Write_Data, RegWrite, fwd_hit, fwd_data, full
  );
endinterface

// File: rtl/wb_write_queue_fifo.sv
// wb_fifo: in-order entry storage; entries are exposed oldest-first (ent[0] is the head)
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  output wb_entry_t        ent [DEPTH],
  output logic [DEPTH-1:0] vld,
  output logic [CNT_W-1:0] count
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) if (push && wr_ptr_q == PTR_W'(i)) mem_d[i] = push_entry;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q, DEPTH) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q, DEPTH) : rd_ptr_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    for (int k = 0; k < DEPTH; k++) begin
      ent[k] = '0;
      vld[k] = k < int'(cnt_q);
      for (int j = 0; j < DEPTH; j++) if (j == (int'(rd_ptr_q) + k) % DEPTH) ent[k] = mem_q[j];
    end
    count = cnt_q;
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: buffered register-file writer with cut-through and forwarding lookup
// Optional retire/stall counters under WB_WRITE_QUEUE_STATS_EN.
module wb_write_queue import wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              Reset,
  wb_write_queue_if.slave  bus
`ifdef WB_WRITE_QUEUE_STATS_EN
  ,
  output logic [15:0]      retire_cnt,
  output logic [15:0]      stall_cnt
`endif
);
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] vld;
  wb_entry_t        ent [DEPTH];
  wb_entry_t        ex_entry, out_q, out_d;
  logic             acc, wr, pop, cut, push, regwrite_q, regwrite_d, hit;
  logic [REG_DATA_W-1:0] fdata;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .Reset(Reset), .push(push), .pop(pop), .push_entry(ex_entry),
    .ent(ent), .vld(vld), .count(count)
  );
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      out_q <= '0;
      regwrite_q <= 1'b0;
    end else begin
      out_q <= out_d;
      regwrite_q <= regwrite_d;
    end
  end
  always_comb begin
    ex_entry = '{rd: bus.ex_rd, data: bus.ex_data};
    bus.ex_ready = (int'(count) < DEPTH) || bus.drain_en;
    acc = bus.ex_valid && bus.ex_ready;
    wr = acc && bus.ex_regwrite;
    pop = bus.drain_en && count != '0;
    cut = bus.drain_en && count == '0 && wr;
    push = wr && !cut;
    regwrite_d = pop || cut;
    out_d = pop ? ent[0] : cut ? ex_entry : out_q;
    // later (younger) matches override older ones and the output register
    hit = regwrite_q && out_q.rd == bus.Rd_IFID;
    fdata = out_q.data;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && ent[k].rd == bus.Rd_IFID) begin
        hit = 1'b1;
        fdata = ent[k].data;
      end
    end
    bus.fwd_hit = hit;
    bus.fwd_data = hit ? fdata : '0;
    bus.full = int'(count) == DEPTH;
    bus.RegWrite = regwrite_q;
    bus.Rd_EXWB = out_q.rd;
    bus.Write_Data = out_q.data;
  end
`ifdef WB_WRITE_QUEUE_STATS_EN
  logic [15:0] retire_q, retire_d, stall_q, stall_d;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      retire_q <= '0;
      stall_q <= '0;
    end else begin
      retire_q <= retire_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    retire_d = retire_q + 16'(regwrite_q);
    stall_d = (bus.ex_valid && !bus.ex_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    retire_cnt = retire_q;
    stall_cnt = stall_q;
  end
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenarios plus random traffic against a queue-based reference model
module tb_wb_write_queue;
  localparam int DEPTH = 2;
  typedef struct { logic [2:0] rd; logic [7:0] data; } ent_t;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int failures = 0;
  ent_t mq[$];
  ent_t m_out = '{rd: 3'd0, data: 8'd0};
  logic m_rw = 1'b0;
  logic [15:0] m_ret = 16'd0;
  logic [15:0] m_stall = 16'd0;
  wb_write_queue_if bus ();
`ifdef WB_WRITE_QUEUE_STATS_EN
  logic [15:0] retire_cnt, stall_cnt;
  wb_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .Reset(Reset), .bus(bus),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt));
`else
  wb_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .Reset(Reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '{rd: 3'd0, data: 8'd0};
    m_rw = 1'b0;
    m_ret = 16'd0;
    m_stall = 16'd0;
  endtask

  // one cycle: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input logic v, input logic rw, input logic [2:0] rd, input logic [7:0] d,
                      input logic dr, input logic [2:0] ird);
    logic er, hit, found;
    logic [7:0] fd;
    ent_t e;
    bus.ex_valid = v; bus.ex_regwrite = rw; bus.ex_rd = rd; bus.ex_data = d;
    bus.drain_en = dr; bus.Rd_IFID = ird;
    #1;
    er = (mq.size() < DEPTH) || dr;
    found = 1'b0; hit = 1'b0; fd = 8'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!found && mq[i].rd == ird) begin found = 1'b1; hit = 1'b1; fd = mq[i].data; end
    end
    if (!found && m_rw && m_out.rd == ird) begin hit = 1'b1; fd = m_out.data; end
    chk("ex_ready", 16'(bus.ex_ready), 16'(er));
    chk("full", 16'(bus.full), 16'(mq.size() == DEPTH));
    chk("fwd_hit", 16'(bus.fwd_hit), 16'(hit));
    chk("fwd_data", 16'(bus.fwd_data), 16'(fd));
    @(posedge clk);
    e = '{rd: rd, data: d};
    m_ret = m_ret + 16'(m_rw);
    if (v && !er && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (dr && mq.size() > 0) begin
      m_out = mq.pop_front();
      m_rw = 1'b1;
      if (v && er && rw) mq.push_back(e);
    end else if (dr && v && er && rw) begin
      m_out = e;
      m_rw = 1'b1;
    end else begin
      m_rw = 1'b0;
      if (v && er && rw) mq.push_back(e);
    end
    #1;
    chk("RegWrite", 16'(bus.RegWrite), 16'(m_rw));
    chk("Rd_EXWB", 16'(bus.Rd_EXWB), 16'(m_out.rd));
    chk("Write_Data", 16'(bus.Write_Data), 16'(m_out.data));
`ifdef WB_WRITE_QUEUE_STATS_EN
    chk("retire_cnt", retire_cnt, m_ret);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  initial begin
    bus.ex_valid = 0; bus.ex_regwrite = 0; bus.ex_rd = 0; bus.ex_data = 0;
    bus.drain_en = 0; bus.Rd_IFID = 0;
    #12;
    chk("rst_RegWrite", 16'(bus.RegWrite), 16'd0);
    chk("rst_Rd_EXWB", 16'(bus.Rd_EXWB), 16'd0);
    chk("rst_Write_Data", 16'(bus.Write_Data), 16'd0);
    chk("rst_full", 16'(bus.full), 16'd0);
    chk("rst_ex_ready", 16'(bus.ex_ready), 16'd1);
    Reset = 1'b1;
    // cut-through
    step(1, 1, 3'd3, 8'h5A, 1, 0);
    chk("ct_RegWrite", 16'(bus.RegWrite), 16'd1);
    chk("ct_rd", 16'(bus.Rd_EXWB), 16'd3);
    chk("ct_data", 16'(bus.Write_Data), 16'h5A);
    step(0, 0, 0, 0, 1, 0);
    chk("ct_strobe_end", 16'(bus.RegWrite), 16'd0);
    // back-pressure, then in-order retire
    step(1, 1, 3'd1, 8'h11, 0, 0);
    step(1, 1, 3'd2, 8'h22, 0, 0);
    chk("bp_full", 16'(bus.full), 16'd1);
    chk("bp_not_ready", 16'(bus.ex_ready), 16'd0);
    step(1, 1, 3'd7, 8'h77, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("bp_first", 16'(bus.Write_Data), 16'h11);
    step(0, 0, 0, 0, 1, 0);
    chk("bp_second", 16'(bus.Write_Data), 16'h22);
    step(0, 0, 0, 0, 1, 0);
    // push and pop while full
    step(1, 1, 3'd1, 8'h31, 0, 0);
    step(1, 1, 3'd2, 8'h32, 0, 0);
    step(1, 1, 3'd4, 8'h44, 1, 0);
    chk("pp_full", 16'(bus.full), 16'd1);
    chk("pp_first", 16'(bus.Write_Data), 16'h31);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pp_last", 16'(bus.Write_Data), 16'h44);
    step(0, 0, 0, 0, 1, 0);
    // forwarding priority
    step(1, 1, 3'd5, 8'hAA, 0, 5);
    step(1, 1, 3'd5, 8'hBB, 0, 5);
    bus.Rd_IFID = 3'd5; #1;
    chk("fwd_young_hit", 16'(bus.fwd_hit), 16'd1);
    chk("fwd_young_data", 16'(bus.fwd_data), 16'hBB);
    bus.Rd_IFID = 3'd6; #1;
    chk("fwd_miss_hit", 16'(bus.fwd_hit), 16'd0);
    chk("fwd_miss_data", 16'(bus.fwd_data), 16'd0);
    // reset mid-stream with two entries pending
    Reset = 1'b0; #1;
    chk("mid_rst_RegWrite", 16'(bus.RegWrite), 16'd0);
    chk("mid_rst_full", 16'(bus.full), 16'd0);
    bus.Rd_IFID = 3'd5; #1;
    chk("mid_rst_fwd", 16'(bus.fwd_hit), 16'd0);
    model_reset();
    #1 Reset = 1'b1;
    step(0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 1, 5);
    chk("no_stale", 16'(bus.RegWrite), 16'd0);
    // non-writing result
    step(1, 0, 3'd3, 8'h33, 1, 3);
    chk("nowrite_rw", 16'(bus.RegWrite), 16'd0);
    step(1, 0, 3'd3, 8'h33, 0, 3);
    chk("nowrite_full", 16'(bus.full), 16'd0);
    // random traffic
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 3'($urandom),
           8'($urandom), 1'($urandom_range(0, 9) < 6), 3'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
